// File: rtl/alu_seq_ctrl.sv
// Multi-precision sequencer for the 8-bit ALU: runs one NBYTES-wide operation through
// the ALU a byte per cycle, LSB first, chaining carry, and returns result plus {Z,N,V,C}.
module alu_seq_ctrl #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_res,
  output logic [3:0]            rsp_flag,
  output logic                  rsp_err,
  output logic [3:0]            alu_opcode,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  output logic [2:0]            alu_shift_amt,
  input  logic [7:0]            alu_res,
  input  logic [3:0]            alu_flag
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_INC = 4'b0110;
  localparam logic [3:0] OP_DEC = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [W-1:0]      a_q, b_q, res_q;
  logic [IDXW-1:0]   idx;
  logic [IDXW+2:0]   bit_ofs;
  logic              carry, zacc, err_q;
  logic [3:0]        flag_q;
  logic              is_arith, last_byte, first_byte;
  logic [7:0]        a_byte, b_byte;

  assign bit_ofs    = {idx, 3'b000};
  assign a_byte     = a_q[bit_ofs +: 8];
  assign b_byte     = b_q[bit_ofs +: 8];
  assign first_byte = (idx == '0);
  assign last_byte  = (idx == IDXW'(NBYTES - 1));
  assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                      (op_q == OP_INC) || (op_q == OP_DEC);

  assign req_ready     = (state == IDLE);
  assign rsp_valid     = (state == DONE);
  assign rsp_res       = res_q;
  assign rsp_flag      = flag_q;
  assign rsp_err       = err_q;
  assign alu_shift_amt = '0;

  // Arithmetic ops all map onto ALU ADD; only operand b and the first-byte carry differ.
  always_comb begin
    state_nxt  = state;
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_op[3] ? DONE : EXEC;
      end
      EXEC: begin
        alu_a      = a_byte;
        alu_opcode = is_arith ? OP_ADD : op_q;
        case (op_q)
          OP_ADD: begin alu_b = b_byte;  alu_cin = first_byte ? 1'b0 : carry; end
          OP_SUB: begin alu_b = ~b_byte; alu_cin = first_byte ? 1'b1 : carry; end
          OP_INC: begin alu_b = 8'h00;   alu_cin = first_byte ? 1'b1 : carry; end
          OP_DEC: begin alu_b = 8'hFF;   alu_cin = first_byte ? 1'b0 : carry; end
          OP_NOT: alu_b = 8'h00;
          default: alu_b = b_byte;
        endcase
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      flag_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            idx    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b1;
            res_q  <= '0;
            flag_q <= '0;
            err_q  <= req_op[3];
          end
        end
        EXEC: begin
          res_q[bit_ofs +: 8] <= alu_res;
          carry               <= alu_flag[0];
          zacc                <= zacc & alu_flag[3];
          idx                 <= idx + 1'b1;
          // N comes from the ALU's own sign flag on the top byte, i.e. result[W-1].
          if (last_byte) begin
            idx    <= '0;
            flag_q <= {zacc & alu_flag[3], alu_flag[2],
                       is_arith & alu_flag[1], is_arith & alu_flag[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
